// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, widths, FSM states.
package alu_pkg;

  localparam int ALU_W       = 19;
  localparam int ALU_NUM_OPS = 14;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_FFT = 4'd10;
  localparam logic [3:0] OP_ENC = 4'd11;
  localparam logic [3:0] OP_DNC = 4'd12;
  localparam logic [3:0] OP_TNF = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Opcode value equals its strobe bit index; out-of-range opcodes give all zeros.
  function automatic logic [ALU_NUM_OPS-1:0] op_onehot(input logic [3:0] op);
    logic [ALU_NUM_OPS-1:0] v;
    for (int i = 0; i < ALU_NUM_OPS; i++) begin
      v[i] = (op == 4'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// requester that was not granted last. Parent updates last_grant on accept.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // One-hot grant, suppressed entirely when not enabled.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b01) begin
        grant = 2'b01;
      end else if (req == 2'b10) begin
        grant = 2'b10;
      end else if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one combinational ALU between two requesters: arbitrates, registers
// operands and strobes, waits an op-dependent number of cycles, then returns
// the captured result over a per-requester valid/ready response channel.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W           = ALU_W,
  parameter int MULDIV_WAIT = 2,
  parameter int BASIC_WAIT  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [3:0]             req0_op,
  input  logic [3:0]             req1_op,
  input  logic [W-1:0]           req0_a,
  input  logic [W-1:0]           req1_a,
  input  logic [W-1:0]           req0_b,
  input  logic [W-1:0]           req1_b,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_ovf,
  output logic                   rsp_err,
  output logic [W-1:0]           alu_ac,
  output logic [W-1:0]           alu_dr,
  output logic [ALU_NUM_OPS-1:0] alu_strobe,
  input  logic [W-1:0]           alu_result,
  input  logic                   alu_ovf,
  output logic                   busy
);

  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT);
  localparam logic [3:0] BASIC_CNT  = 4'(BASIC_WAIT);

  state_t                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   id_q, id_d;
  logic                   last_grant_q, last_grant_d;
  logic [W-1:0]           ac_q, ac_d;
  logic [W-1:0]           dr_q, dr_d;
  logic [ALU_NUM_OPS-1:0] strobe_q, strobe_d;
  logic [W-1:0]           data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;

  logic [1:0]   grant;
  logic         sel_id;
  logic [3:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (state_q == S_IDLE),
    .grant      (grant)
  );

  assign req_ready  = grant;
  assign sel_id     = grant[1];
  assign sel_op     = sel_id ? req1_op : req0_op;
  assign sel_a      = sel_id ? req1_a  : req0_a;
  assign sel_b      = sel_id ? req1_b  : req0_b;

  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = data_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_err    = err_q;
  assign alu_ac     = ac_q;
  assign alu_dr     = dr_q;
  assign alu_strobe = strobe_q;

  // Next-state logic. EXEC spends its first cycle raising the strobe (operands
  // are already registered), then holds it for cnt+1 cycles before capture.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    ac_d         = ac_q;
    dr_d         = dr_q;
    strobe_d     = strobe_q;
    data_d       = data_q;
    ovf_d        = ovf_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          op_d         = sel_op;
          ac_d         = sel_a;
          dr_d         = sel_b;
          id_d         = sel_id;
          last_grant_d = sel_id;
          if (sel_op <= OP_TNF) begin
            cnt_d   = (sel_op == OP_MUL || sel_op == OP_DIV) ? MULDIV_CNT : BASIC_CNT;
            state_d = S_EXEC;
          end else begin
            data_d  = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_EXEC: begin
        if (strobe_q == '0) begin
          strobe_d = op_onehot(op_q);
        end else if (cnt_q == 4'd0) begin
          data_d   = alu_result;
          ovf_d    = alu_ovf;
          err_d    = 1'b0;
          strobe_d = '0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready[id_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      ac_q         <= '0;
      dr_q         <= '0;
      strobe_q     <= '0;
      data_q       <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      ac_q         <= ac_d;
      dr_q         <= dr_d;
      strobe_q     <= strobe_d;
      data_q       <= data_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU attached.
module tb_alu_sequencer;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_ovf, rsp_err;
  logic [W-1:0] alu_ac, alu_dr;
  logic [13:0]  alu_strobe;
  logic [W-1:0] alu_result;
  logic         alu_ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W), .MULDIV_WAIT(2), .BASIC_WAIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req1_a     (req1_a),
    .req0_b     (req0_b),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .alu_ac     (alu_ac),
    .alu_dr     (alu_dr),
    .alu_strobe (alu_strobe),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .busy       (busy)
  );

  // Stand-in ALU: signed overflow on ADD/SUB, high-half overflow on MUL, x/0 = 0.
  logic [W-1:0]   alu_tmp;
  logic [2*W-1:0] alu_prod;
  always_comb begin
    alu_tmp    = '0;
    alu_prod   = '0;
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_strobe)
      14'h0001: begin
        alu_tmp    = alu_ac + alu_dr;
        alu_result = alu_tmp;
        alu_ovf    = (alu_ac[W-1] == alu_dr[W-1]) && (alu_tmp[W-1] != alu_ac[W-1]);
      end
      14'h0002: begin
        alu_tmp    = alu_ac - alu_dr;
        alu_result = alu_tmp;
        alu_ovf    = (alu_ac[W-1] != alu_dr[W-1]) && (alu_tmp[W-1] != alu_ac[W-1]);
      end
      14'h0004: begin
        alu_prod   = {{W{1'b0}}, alu_ac} * {{W{1'b0}}, alu_dr};
        alu_result = alu_prod[W-1:0];
        alu_ovf    = |alu_prod[2*W-1:W];
      end
      14'h0008: alu_result = (alu_dr == '0) ? '0 : alu_ac / alu_dr;
      14'h0010: alu_result = alu_ac & alu_dr;
      14'h0020: alu_result = alu_ac | alu_dr;
      14'h0040: alu_result = alu_ac ^ alu_dr;
      default:  alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle just after the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_op = '0; req1_op = '0; req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
    step(2);

    // Reset state
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_strobe", 32'(alu_strobe), 32'h0);
    check("rst_ac", 32'(alu_ac), 32'h0);
    check("rst_data", 32'(rsp_data), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Tie from reset: req0 first, then req1, then req0 again
    req_valid = 2'b11; rsp_ready = 2'b11;
    req0_op = 4'd0; req0_a = 19'd1; req0_b = 19'd1;
    req1_op = 4'd1; req1_a = 19'd5; req1_b = 19'd2;
    #1 check("tie1_ready", 32'(req_ready), 32'h1);
    step(1);
    check("tie1_exec_ready", 32'(req_ready), 32'h0);
    check("tie1_busy", 32'(busy), 32'h1);
    step(1);
    check("tie1_strobe", 32'(alu_strobe), 32'h0001);
    step(1);
    check("tie1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("tie1_data", 32'(rsp_data), 32'h2);
    step(1);
    check("tie2_ready", 32'(req_ready), 32'h2);
    step(3);
    check("tie2_rsp_valid", 32'(rsp_valid), 32'h2);
    check("tie2_data", 32'(rsp_data), 32'h3);
    step(1);
    check("tie3_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    step(1);
    check("tie3_idle", 32'(busy), 32'h0);
    $display("tie: req0 then req1 then req0");

    // ADD with signed overflow
    req_valid = 2'b01; rsp_ready = 2'b01;
    req0_op = 4'd0; req0_a = 19'h3FFFF; req0_b = 19'd1;
    #1 check("add_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b00;
    check("add_t0_strobe", 32'(alu_strobe), 32'h0);
    check("add_ac", 32'(alu_ac), 32'h3FFFF);
    check("add_dr", 32'(alu_dr), 32'h1);
    step(1);
    check("add_strobe", 32'(alu_strobe), 32'h0001);
    check("add_early_valid", 32'(rsp_valid), 32'h0);
    step(1);
    check("add_strobe_off", 32'(alu_strobe), 32'h0);
    check("add_rsp_valid", 32'(rsp_valid), 32'h1);
    check("add_data", 32'(rsp_data), 32'h40000);
    check("add_ovf", 32'(rsp_ovf), 32'h1);
    check("add_err", 32'(rsp_err), 32'h0);
    step(1);
    check("add_done", 32'(rsp_valid), 32'h0);
    $display("add: 3FFFF+1 -> %0h ovf=%0d", rsp_data, rsp_ovf);

    // MUL on requester 1, three strobe cycles
    req_valid = 2'b10; rsp_ready = 2'b10;
    req1_op = 4'd2; req1_a = 19'd3; req1_b = 19'd5;
    #1 check("mul_ready", 32'(req_ready), 32'h2);
    step(1);
    req_valid = 2'b00;
    check("mul_t0_strobe", 32'(alu_strobe), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("mul_strobe", 32'(alu_strobe), 32'h0004);
      check("mul_wait_valid", 32'(rsp_valid), 32'h0);
    end
    step(1);
    check("mul_strobe_off", 32'(alu_strobe), 32'h0);
    check("mul_rsp_valid", 32'(rsp_valid), 32'h2);
    check("mul_data", 32'(rsp_data), 32'd15);
    check("mul_ovf", 32'(rsp_ovf), 32'h0);
    step(1);
    $display("mul: 3*5 -> %0d", rsp_data);

    // Illegal opcode
    req_valid = 2'b01; rsp_ready = 2'b01;
    req0_op = 4'd15; req0_a = 19'd9; req0_b = 19'd9;
    #1 check("ill_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b00;
    check("ill_strobe", 32'(alu_strobe), 32'h0);
    check("ill_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ill_data", 32'(rsp_data), 32'h0);
    check("ill_err", 32'(rsp_err), 32'h1);
    step(1);
    check("ill_done", 32'(busy), 32'h0);
    $display("illegal: op=15 err=1");

    // DIV by zero under backpressure; req1 waits
    req_valid = 2'b01; rsp_ready = 2'b00;
    req0_op = 4'd3; req0_a = 19'd7; req0_b = 19'd0;
    #1 check("div_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b10;
    req1_op = 4'd0; req1_a = 19'd4; req1_b = 19'd4;
    step(3);
    check("div_strobe", 32'(alu_strobe), 32'h0008);
    step(1);
    check("div_rsp_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      check("div_hold_valid", 32'(rsp_valid), 32'h1);
      check("div_hold_data", 32'(rsp_data), 32'h0);
      check("div_hold_ovf", 32'(rsp_ovf), 32'h0);
      check("div_hold_busy", 32'(busy), 32'h1);
      check("div_hold_req1", 32'(req_ready), 32'h0);
      step(1);
    end
    rsp_ready = 2'b01;
    #1 check("div_ack_req1", 32'(req_ready), 32'h0);
    step(1);
    check("div_released", 32'(rsp_valid), 32'h0);
    check("req1_ready_after", 32'(req_ready), 32'h2);
    rsp_ready = 2'b10;
    step(1);
    req_valid = 2'b00;
    step(2);
    check("req1_rsp_valid", 32'(rsp_valid), 32'h2);
    check("req1_data", 32'(rsp_data), 32'd8);
    step(1);
    $display("div: 7/0 -> %0d held under backpressure, then req1 served", 0);

    // Reset during MUL
    req_valid = 2'b10; rsp_ready = 2'b10;
    req1_op = 4'd2; req1_a = 19'd3; req1_b = 19'd5;
    step(1);
    req_valid = 2'b00;
    step(1);
    check("rmid_strobe", 32'(alu_strobe), 32'h0004);
    rst_n = 1'b0;
    #1;
    check("rmid_strobe0", 32'(alu_strobe), 32'h0);
    check("rmid_busy0", 32'(busy), 32'h0);
    check("rmid_ac0", 32'(alu_ac), 32'h0);
    step(3);
    check("rmid_no_rsp", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b01;
    req0_op = 4'd0; req0_a = 19'd1; req0_b = 19'd1;
    req1_op = 4'd1; req1_a = 19'd5; req1_b = 19'd2;
    #1 check("rmid_tie_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b00;
    step(2);
    check("rmid_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rmid_data", 32'(rsp_data), 32'h2);
    step(1);
    $display("reset mid-exec: aborted, tie then granted req0");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
